// File: rtl/text_console.sv
// text_console: writable text-mode tile buffer with control codes and auto-scroll.
// Optional cursor blink (fg/bg swap at the cursor cell): define TEXT_CONSOLE_CURSOR_EN.
module text_console #(
    parameter int TEXT_COLS     = 20,
    parameter int TEXT_ROWS     = 6,
    parameter int TILE_NUM_BITS = 8,
    parameter int CHAR_BITS     = 8,
    parameter int PIXEL_BITS    = 16,
    parameter int FIRST_CHAR    = 32,
    parameter logic [PIXEL_BITS-1:0] DEFAULT_FG = 16'hffff,
    parameter logic [PIXEL_BITS-1:0] DEFAULT_BG = 16'h001f,
    parameter int BLINK_CYCLES  = 13_500_000
) (
    input  logic                         in_clk,
    input  logic                         in_rst,
    input  logic [CHAR_BITS-1:0]         in_char,
    input  logic [PIXEL_BITS-1:0]        in_fg,
    input  logic [PIXEL_BITS-1:0]        in_bg,
    input  logic                         in_char_valid,
    output logic                         out_char_ready,
    input  logic                         in_clear,
    input  logic [TILE_NUM_BITS-1:0]     in_rd_addr,
    output logic [CHAR_BITS-1:0]         out_rd_char,
    output logic [PIXEL_BITS-1:0]        out_rd_fg,
    output logic [PIXEL_BITS-1:0]        out_rd_bg,
    output logic [$clog2(TEXT_COLS)-1:0] out_cursor_x,
    output logic [$clog2(TEXT_ROWS)-1:0] out_cursor_y,
    output logic                         out_busy
);

    localparam int N      = TEXT_COLS * TEXT_ROWS;
    localparam int AW     = $clog2(N);
    localparam int X_BITS = $clog2(TEXT_COLS);
    localparam int Y_BITS = $clog2(TEXT_ROWS);

    localparam logic [TILE_NUM_BITS-1:0] LAST_CELL  = TILE_NUM_BITS'(N - 1);
    localparam logic [TILE_NUM_BITS-1:0] ROW_BASE   = TILE_NUM_BITS'((TEXT_ROWS - 1) * TEXT_COLS);
    localparam logic [TILE_NUM_BITS-1:0] BLANK_LAST = TILE_NUM_BITS'(TEXT_COLS - 1);
    localparam logic [TILE_NUM_BITS-1:0] COLS_T     = TILE_NUM_BITS'(TEXT_COLS);
    localparam logic [TILE_NUM_BITS-1:0] N_T        = TILE_NUM_BITS'(N);
    localparam logic [X_BITS-1:0]        X_LAST     = X_BITS'(TEXT_COLS - 1);
    localparam logic [Y_BITS-1:0]        Y_LAST     = Y_BITS'(TEXT_ROWS - 1);

    localparam logic [CHAR_BITS-1:0] SPACE    = CHAR_BITS'(32);
    localparam logic [CHAR_BITS-1:0] PRINT_LO = CHAR_BITS'(FIRST_CHAR);
    localparam logic [CHAR_BITS-1:0] PRINT_HI = CHAR_BITS'(126);
    localparam logic [CHAR_BITS-1:0] C_BS     = CHAR_BITS'(8);
    localparam logic [CHAR_BITS-1:0] C_LF     = CHAR_BITS'(10);
    localparam logic [CHAR_BITS-1:0] C_FF     = CHAR_BITS'(12);
    localparam logic [CHAR_BITS-1:0] C_CR     = CHAR_BITS'(13);

    typedef enum logic [1:0] {CLEAR, IDLE, SCROLL_COPY, SCROLL_BLANK} state_t;

    state_t                   state, state_n;
    logic [TILE_NUM_BITS-1:0] cnt, cnt_n;
    logic [X_BITS-1:0]        cursor_x, cursor_x_n;
    logic [Y_BITS-1:0]        cursor_y, cursor_y_n;
    logic                     clear_pending, clear_pending_n;

    logic                     we;
    logic [TILE_NUM_BITS-1:0] waddr;
    logic [CHAR_BITS-1:0]     wchar;
    logic [PIXEL_BITS-1:0]    wfg, wbg;

    logic [CHAR_BITS-1:0]     char_mem [N];
    logic [PIXEL_BITS-1:0]    fg_mem   [N];
    logic [PIXEL_BITS-1:0]    bg_mem   [N];

    logic [CHAR_BITS-1:0]     scroll_char;
    logic [PIXEL_BITS-1:0]    scroll_fg, scroll_bg;
    logic [CHAR_BITS-1:0]     rd_char_q;
    logic [PIXEL_BITS-1:0]    rd_fg_q, rd_bg_q;
    logic [TILE_NUM_BITS-1:0] cur_cell;

    assign cur_cell       = TILE_NUM_BITS'(cursor_y) * COLS_T + TILE_NUM_BITS'(cursor_x);
    assign out_char_ready = (state == IDLE) && !in_clear && !clear_pending;
    assign out_busy       = (state != IDLE);
    assign out_cursor_x   = cursor_x;
    assign out_cursor_y   = cursor_y;
    assign out_rd_char    = rd_char_q;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state         <= CLEAR;
            cnt           <= '0;
            cursor_x      <= '0;
            cursor_y      <= '0;
            clear_pending <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            cursor_x      <= cursor_x_n;
            cursor_y      <= cursor_y_n;
            clear_pending <= clear_pending_n;
        end
    end

    always_comb begin
        state_n         = state;
        cnt_n           = cnt;
        cursor_x_n      = cursor_x;
        cursor_y_n      = cursor_y;
        clear_pending_n = clear_pending;
        we              = 1'b0;
        waddr           = cnt;
        wchar           = SPACE;
        wfg             = DEFAULT_FG;
        wbg             = DEFAULT_BG;
        case (state)
            CLEAR: begin
                we              = 1'b1;
                clear_pending_n = 1'b0;
                if (cnt == LAST_CELL) begin
                    state_n    = IDLE;
                    cnt_n      = '0;
                    cursor_x_n = '0;
                    cursor_y_n = '0;
                end else begin
                    cnt_n = cnt + TILE_NUM_BITS'(1);
                end
            end
            IDLE: begin
                if (in_clear) begin
                    state_n = CLEAR;
                    cnt_n   = '0;
                end else if (in_char_valid) begin
                    if (in_char >= PRINT_LO && in_char <= PRINT_HI) begin
                        we    = 1'b1;
                        waddr = cur_cell;
                        wchar = in_char;
                        wfg   = in_fg;
                        wbg   = in_bg;
                        if (cursor_x == X_LAST) begin
                            cursor_x_n = '0;
                            if (cursor_y == Y_LAST) begin
                                state_n = SCROLL_COPY;
                                cnt_n   = '0;
                            end else begin
                                cursor_y_n = cursor_y + Y_BITS'(1);
                            end
                        end else begin
                            cursor_x_n = cursor_x + X_BITS'(1);
                        end
                    end else if (in_char == C_LF) begin
                        cursor_x_n = '0;
                        if (cursor_y == Y_LAST) begin
                            state_n = SCROLL_COPY;
                            cnt_n   = '0;
                        end else begin
                            cursor_y_n = cursor_y + Y_BITS'(1);
                        end
                    end else if (in_char == C_CR) begin
                        cursor_x_n = '0;
                    end else if (in_char == C_BS) begin
                        if (cursor_x != '0) cursor_x_n = cursor_x - X_BITS'(1);
                    end else if (in_char == C_FF) begin
                        state_n = CLEAR;
                        cnt_n   = '0;
                    end
                end
            end
            SCROLL_COPY: begin
                if (in_clear) clear_pending_n = 1'b1;
                // scroll_* holds cell cnt-1+COLS, read on the previous cycle
                if (cnt != '0) begin
                    we    = 1'b1;
                    waddr = cnt - TILE_NUM_BITS'(1);
                    wchar = scroll_char;
                    wfg   = scroll_fg;
                    wbg   = scroll_bg;
                end
                if (cnt == ROW_BASE) begin
                    state_n = SCROLL_BLANK;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + TILE_NUM_BITS'(1);
                end
            end
            SCROLL_BLANK: begin
                we    = 1'b1;
                waddr = ROW_BASE + cnt;
                if (in_clear) clear_pending_n = 1'b1;
                if (cnt == BLANK_LAST) begin
                    cnt_n = '0;
                    if (clear_pending || in_clear) begin
                        state_n         = CLEAR;
                        clear_pending_n = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + TILE_NUM_BITS'(1);
                end
            end
            default: state_n = CLEAR;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (we) begin
            char_mem[AW'(waddr)] <= wchar;
            fg_mem[AW'(waddr)]   <= wfg;
            bg_mem[AW'(waddr)]   <= wbg;
        end
        if (cnt < ROW_BASE) begin
            scroll_char <= char_mem[AW'(cnt + COLS_T)];
            scroll_fg   <= fg_mem[AW'(cnt + COLS_T)];
            scroll_bg   <= bg_mem[AW'(cnt + COLS_T)];
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            rd_char_q <= SPACE;
            rd_fg_q   <= DEFAULT_FG;
            rd_bg_q   <= DEFAULT_BG;
        end else if (in_rd_addr < N_T) begin
            rd_char_q <= char_mem[AW'(in_rd_addr)];
            rd_fg_q   <= fg_mem[AW'(in_rd_addr)];
            rd_bg_q   <= bg_mem[AW'(in_rd_addr)];
        end else begin
            rd_char_q <= SPACE;
            rd_fg_q   <= DEFAULT_FG;
            rd_bg_q   <= DEFAULT_BG;
        end
    end

`ifdef TEXT_CONSOLE_CURSOR_EN
    localparam int BLINK_W = $clog2(BLINK_CYCLES);

    logic [BLINK_W-1:0]       blink_cnt;
    logic                     blink_phase;
    logic [TILE_NUM_BITS-1:0] rd_addr_q;
    logic                     swap;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            rd_addr_q   <= '0;
        end else begin
            rd_addr_q <= in_rd_addr;
            if (blink_cnt == BLINK_W'(BLINK_CYCLES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    assign swap      = blink_phase && (state == IDLE) && (rd_addr_q == cur_cell);
    assign out_rd_fg = swap ? rd_bg_q : rd_fg_q;
    assign out_rd_bg = swap ? rd_fg_q : rd_bg_q;
`else
    assign out_rd_fg = rd_fg_q;
    assign out_rd_bg = rd_bg_q;
`endif

endmodule

// File: tb/tb_text_console.sv
// Self-checking bench for text_console: directed vectors plus a cell-array reference model
// compared against busy/ready/cursor/read-port outputs every cycle.
module tb_text_console;

    localparam int C = 20;
    localparam int R = 6;
    localparam int N = C * R;
    localparam logic [15:0] DFG = 16'hffff;
    localparam logic [15:0] DBG = 16'h001f;

    logic        clk;
    logic        rst;
    logic [7:0]  in_char;
    logic [15:0] in_fg, in_bg;
    logic        in_char_valid;
    logic        out_char_ready;
    logic        in_clear;
    logic [7:0]  in_rd_addr;
    logic [7:0]  out_rd_char;
    logic [15:0] out_rd_fg, out_rd_bg;
    logic [4:0]  out_cursor_x;
    logic [2:0]  out_cursor_y;
    logic        out_busy;

    int errors = 0;
    int checks = 0;

    text_console #(
        .TEXT_COLS(C),
        .TEXT_ROWS(R),
        .TILE_NUM_BITS(8),
        .CHAR_BITS(8),
        .PIXEL_BITS(16),
        .FIRST_CHAR(32),
        .DEFAULT_FG(DFG),
        .DEFAULT_BG(DBG)
    ) dut (
        .in_clk(clk),
        .in_rst(rst),
        .in_char(in_char),
        .in_fg(in_fg),
        .in_bg(in_bg),
        .in_char_valid(in_char_valid),
        .out_char_ready(out_char_ready),
        .in_clear(in_clear),
        .in_rd_addr(in_rd_addr),
        .out_rd_char(out_rd_char),
        .out_rd_fg(out_rd_fg),
        .out_rd_bg(out_rd_bg),
        .out_cursor_x(out_cursor_x),
        .out_cursor_y(out_cursor_y),
        .out_busy(out_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cell array updated atomically per accepted operation,
    // plus a count of remaining busy cycles.
    logic [7:0]  m_char [N];
    logic [15:0] m_fg   [N];
    logic [15:0] m_bg   [N];
    int          m_x, m_y, m_busy;
    bit          m_scrolling, m_pend;
    bit          e_valid;
    logic [7:0]  e_char;
    logic [15:0] e_fg, e_bg;

    task m_blank(input int i);
        m_char[i] = 8'h20;
        m_fg[i]   = DFG;
        m_bg[i]   = DBG;
    endtask

    task m_start_clear();
        for (int i = 0; i < N; i++) m_blank(i);
        m_x = 0;
        m_y = 0;
        m_busy = N;
        m_scrolling = 0;
    endtask

    task m_newline();
        if (m_y == R - 1) begin
            for (int i = 0; i < (R - 1) * C; i++) begin
                m_char[i] = m_char[i + C];
                m_fg[i]   = m_fg[i + C];
                m_bg[i]   = m_bg[i + C];
            end
            for (int i = (R - 1) * C; i < N; i++) m_blank(i);
            m_busy = (R - 1) * C + 1 + C;
            m_scrolling = 1;
        end else begin
            m_y++;
        end
    endtask

    task m_accept(input logic [7:0] c, input logic [15:0] fg, input logic [15:0] bg);
        if (c >= 8'd32 && c <= 8'h7e) begin
            m_char[m_y * C + m_x] = c;
            m_fg[m_y * C + m_x]   = fg;
            m_bg[m_y * C + m_x]   = bg;
            if (m_x == C - 1) begin
                m_x = 0;
                m_newline();
            end else begin
                m_x++;
            end
        end else if (c == 8'h0a) begin
            m_x = 0;
            m_newline();
        end else if (c == 8'h0d) begin
            m_x = 0;
        end else if (c == 8'h08) begin
            if (m_x > 0) m_x--;
        end else if (c == 8'h0c) begin
            m_start_clear();
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) m_blank(i);
            m_x = 0;
            m_y = 0;
            m_busy = N;
            m_scrolling = 0;
            m_pend = 0;
            e_valid = 1;
            e_char = 8'h20;
            e_fg = DFG;
            e_bg = DBG;
        end else begin
            e_valid = (m_busy == 0) || (int'(in_rd_addr) >= N);
            if (int'(in_rd_addr) >= N) begin
                e_char = 8'h20;
                e_fg = DFG;
                e_bg = DBG;
            end else begin
                e_char = m_char[in_rd_addr];
                e_fg = m_fg[in_rd_addr];
                e_bg = m_bg[in_rd_addr];
            end
            if (m_busy > 0) begin
                if (m_scrolling && in_clear) m_pend = 1;
                m_busy--;
                if (m_busy == 0) begin
                    m_scrolling = 0;
                    if (m_pend) begin
                        m_pend = 0;
                        m_start_clear();
                    end
                end
            end else if (in_clear) begin
                m_start_clear();
            end else if (in_char_valid) begin
                m_accept(in_char, in_fg, in_bg);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        chk("busy", 32'(out_busy), 32'(m_busy != 0));
        chk("ready", 32'(out_char_ready), 32'(m_busy == 0 && !in_clear));
        if (m_busy == 0) begin
            chk("cursor_x", 32'(out_cursor_x), 32'(m_x));
            chk("cursor_y", 32'(out_cursor_y), 32'(m_y));
        end
        if (e_valid) begin
            chk("rd_char", 32'(out_rd_char), 32'(e_char));
            chk("rd_fg", 32'(out_rd_fg), 32'(e_fg));
            chk("rd_bg", 32'(out_rd_bg), 32'(e_bg));
        end
    end

    task automatic send(input logic [7:0] c, input logic [15:0] fg, input logic [15:0] bg);
        int n = 0;
        @(negedge clk);
        in_char = c;
        in_fg = fg;
        in_bg = bg;
        in_char_valid = 1'b1;
        #1;
        while (!out_char_ready && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!out_char_ready) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: ready never rose for code %0h", c);
        end else begin
            @(posedge clk);
        end
        @(negedge clk);
        in_char_valid = 1'b0;
    endtask

    // Counts clock edges until out_busy falls (starting just after the edge that began the operation).
    task automatic busy_count(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (out_busy && n < 2000);
    endtask

    task automatic wait_idle();
        int n;
        busy_count(n);
        if (out_busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy still %0d after %0d cycles", out_busy, n);
        end
    endtask

    task automatic rd_lit(input string name, input logic [7:0] a, input logic [7:0] ch,
                          input logic [15:0] fg, input logic [15:0] bg);
        @(negedge clk);
        in_rd_addr = a;
        @(posedge clk);
        #1;
        chk({name, "_char"}, 32'(out_rd_char), 32'(ch));
        chk({name, "_fg"}, 32'(out_rd_fg), 32'(fg));
        chk({name, "_bg"}, 32'(out_rd_bg), 32'(bg));
    endtask

    task automatic cur_lit(input string name, input int x, input int y);
        chk({name, "_x"}, 32'(out_cursor_x), 32'(x));
        chk({name, "_y"}, 32'(out_cursor_y), 32'(y));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        int n;
        in_char = 8'h00;
        in_fg = '0;
        in_bg = '0;
        in_char_valid = 1'b0;
        in_clear = 1'b0;
        in_rd_addr = 8'd0;
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(out_busy), 32'd1);
        chk("rst_ready", 32'(out_char_ready), 32'd0);
        chk("rst_rd_char", 32'(out_rd_char), 32'h20);
        chk("rst_rd_fg", 32'(out_rd_fg), 32'hffff);
        chk("rst_rd_bg", 32'(out_rd_bg), 32'h001f);
        cur_lit("rst_cursor", 0, 0);
        rst = 1'b0;
        busy_count(n);
        chk("initial_clear_cycles", 32'(n), 32'd120);
        chk("ready_after_clear", 32'(out_char_ready), 32'd1);
        for (int a = 0; a < N; a++) begin
            @(negedge clk);
            in_rd_addr = 8'(a);
        end

        send(8'h41, 16'hf800, 16'h0000);
        rd_lit("first_char", 8'd0, 8'h41, 16'hf800, 16'h0000);
        cur_lit("after_A", 1, 0);

        send(8'h0c, 16'h0, 16'h0);
        wait_idle();
        cur_lit("after_ff", 0, 0);
        for (int i = 0; i < 20; i++) send(8'h61 + 8'(i), 16'h1234, 16'h5678);
        cur_lit("row_wrap", 0, 1);
        send(8'h08, 16'h0, 16'h0);
        cur_lit("bs_at_col0", 0, 1);
        send(8'h0a, 16'h0, 16'h0);
        send(8'h71, 16'h00ff, 16'hff00);
        send(8'h08, 16'h0, 16'h0);
        cur_lit("bs_mid", 0, 2);
        rd_lit("bs_keeps_cell", 8'd40, 8'h71, 16'h00ff, 16'hff00);
        for (int i = 0; i < 5; i++) send(8'h78, 16'h0f0f, 16'hf0f0);
        cur_lit("five_x", 5, 2);
        send(8'h0d, 16'h0, 16'h0);
        cur_lit("cr", 0, 2);

        send(8'h0c, 16'h0, 16'h0);
        wait_idle();
        for (int i = 0; i < N - 1; i++) send(8'h41 + 8'(i % 26), 16'h07e0, 16'h0000);
        cur_lit("before_scroll", 19, 5);
        send(8'h41 + 8'((N - 1) % 26), 16'h07e0, 16'h0000);
        busy_count(n);
        chk("scroll_cycles", 32'(n), 32'd121);
        cur_lit("after_scroll", 0, 5);
        rd_lit("scroll_cell0", 8'd0, 8'h55, 16'h07e0, 16'h0000);
        rd_lit("scroll_cell99", 8'd99, 8'h50, 16'h07e0, 16'h0000);
        rd_lit("scroll_cell100", 8'd100, 8'h20, 16'hffff, 16'h001f);
        rd_lit("scroll_cell119", 8'd119, 8'h20, 16'hffff, 16'h001f);

        send(8'h0a, 16'h0, 16'h0);
        n = 0;
        repeat (50) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        in_clear = 1'b1;
        @(posedge clk);
        n++;
        @(negedge clk);
        in_clear = 1'b0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (out_busy && n < 2000);
        chk("scroll_then_clear_cycles", 32'(n), 32'd241);
        cur_lit("after_pending_clear", 0, 0);

        @(negedge clk);
        in_char = 8'h42;
        in_fg = 16'haaaa;
        in_bg = 16'h5555;
        in_char_valid = 1'b1;
        in_clear = 1'b1;
        #1;
        chk("ready_low_with_clear", 32'(out_char_ready), 32'd0);
        @(negedge clk);
        in_char_valid = 1'b0;
        in_clear = 1'b0;
        busy_count(n);
        chk("idle_clear_cycles", 32'(n), 32'd120);
        rd_lit("no_B_written", 8'd0, 8'h20, 16'hffff, 16'h001f);
        cur_lit("after_idle_clear", 0, 0);

        rd_lit("out_of_range", 8'd125, 8'h20, 16'hffff, 16'h001f);
        send(8'h5a, 16'hbeef, 16'h0123);
        send(8'h07, 16'h0, 16'h0);
        cur_lit("bell_ignored", 1, 0);
        rd_lit("bell_cell", 8'd0, 8'h5a, 16'hbeef, 16'h0123);
        rd_lit("bell_cell1", 8'd1, 8'h20, 16'hffff, 16'h001f);

        send(8'h0c, 16'h0, 16'h0);
        repeat (50) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        busy_count(n);
        chk("reset_mid_clear_cycles", 32'(n), 32'd120);
        rd_lit("after_reset_clear", 8'd0, 8'h20, 16'hffff, 16'h001f);
        cur_lit("after_reset_clear", 0, 0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/text_console.md
Name: text_console

Overview:
- Writable text-mode buffer: successor to the fixed text/colour ROMs feeding the font renderer of the serial LCD design.
- Accepts a character stream over a valid/ready handshake and stores character plus fg/bg colour per tile.
- Interprets control codes (newline, carriage return, backspace, form feed); scrolls the screen automatically.
- Exposes a registered read port addressed by tile_num, feeding the font ROM and pixel colour mux.

Parameters:
TEXT_COLS, 20, characters per row
TEXT_ROWS, 6, text rows
TILE_NUM_BITS, 8, read/cell address width (must cover TEXT_COLS*TEXT_ROWS plus the partial bottom line)
CHAR_BITS, 8, character code width
PIXEL_BITS, 16, colour width (RGB565)
FIRST_CHAR, 32, lowest printable code
DEFAULT_FG, 16'hffff, fg colour after clear/scroll and for out-of-range reads
DEFAULT_BG, 16'h001f, bg colour after clear/scroll and for out-of-range reads
BLINK_CYCLES, 13_500_000, half-period of the cursor blink (optional feature only)

Ports:
in_clk  in  1  main clock
in_rst  in  1  asynchronous, active-high reset
in_char  in  CHAR_BITS  character/control code
in_fg  in  PIXEL_BITS  fg colour stored with in_char
in_bg  in  PIXEL_BITS  bg colour stored with in_char
in_char_valid  in  1  in_char/in_fg/in_bg are valid
out_char_ready  out  1  console accepts a character this cycle
in_clear  in  1  request a full-screen clear (one-cycle pulse)
in_rd_addr  in  TILE_NUM_BITS  read address (tile_num)
out_rd_char  out  CHAR_BITS  character at in_rd_addr
out_rd_fg  out  PIXEL_BITS  fg colour at in_rd_addr
out_rd_bg  out  PIXEL_BITS  bg colour at in_rd_addr
out_cursor_x  out  $clog2(TEXT_COLS)  cursor column
out_cursor_y  out  $clog2(TEXT_ROWS)  cursor row
out_busy  out  1  clear or scroll in progress

Behaviour:
- Reset values:
  - cursor (0,0); out_char_ready=0; out_busy=1.
  - Read outputs: 0x20, DEFAULT_FG, DEFAULT_BG.
  - State = CLEAR, counter=0.
  - Reset mid-operation aborts it and restarts CLEAR.
- States: CLEAR, IDLE, SCROLL_COPY, SCROLL_BLANK.
- CLEAR:
  - Writes 0x20/DEFAULT_FG/DEFAULT_BG to one cell per cycle, cells 0..N-1, N=TEXT_COLS*TEXT_ROWS.
  - Exactly N cycles, then cursor=(0,0) and IDLE.
- out_char_ready = (state==IDLE) && !in_clear && !clear_pending. Handshake completes on valid&&ready at the rising edge.
- Accepted codes:
  - FIRST_CHAR..0x7e: write char+colours at cell y*TEXT_COLS+x, then x+1.
    - If x was TEXT_COLS-1: x=0, y+1.
    - If y was TEXT_ROWS-1: y stays, enter SCROLL_COPY.
  - 0x0a: x=0; y+1, or SCROLL_COPY if y==TEXT_ROWS-1.
  - 0x0d: x=0.
  - 0x08: x-1 if x>0, else no change. Cell contents unchanged.
  - 0x0c: enter CLEAR.
  - Any other code: accepted and discarded; no state change.
- SCROLL_COPY:
  - Copies cell i+TEXT_COLS to cell i for i=0..(TEXT_ROWS-1)*TEXT_COLS-1.
  - Internal read latency 1, pipelined one cell/cycle; takes (TEXT_ROWS-1)*TEXT_COLS+1 cycles.
- SCROLL_BLANK: writes defaults to the last row, TEXT_COLS cycles, then IDLE. Cursor stays at (0, TEXT_ROWS-1).
- in_clear:
  - In IDLE: enters CLEAR next cycle. A same-cycle character is not accepted, because ready is low.
  - In any other state: latched in clear_pending and executed on completion of the current operation.
  - In CLEAR: ignored.
- Read port:
  - Registered, latency 1, independent of the write side, valid in every state.
  - During CLEAR/scroll it returns the current RAM contents.
  - in_rd_addr >= N returns 0x20, DEFAULT_FG, DEFAULT_BG.
- Storage: three RAMs of depth N (char, fg, bg). Each has a write port plus two read ports (display, scroll), or is duplicated for inference.

Optional Feature:
TEXT_CONSOLE_CURSOR_EN
- Defined:
  - A counter toggles a blink phase every BLINK_CYCLES cycles; reset phase is 0.
  - While the phase is 1, state==IDLE and the registered read address equals the cursor cell, out_rd_fg and out_rd_bg are swapped.
- Undefined: no counter and no swap; BLINK_CYCLES unused.

Test Plan:
- Release reset -> out_busy=1 for exactly 120 cycles, then out_char_ready=1. Read addr 0..119 all return 0x20/16'hffff/16'h001f.
- Send 0x41 with fg 16'hf800, bg 16'h0000 -> read addr 0 next cycle gives 0x41/16'hf800/16'h0000; cursor (1,0).
- Send 20 printable chars from (0,0) -> cursor (0,1). Then 0x08 -> cursor unchanged (0,1); 0x0d at (5,2) -> (0,2).
- Fill 120 cells ('A'+i%26) -> scroll starts, busy 101+20=121 cycles. Then cell 0 = former cell 20 ('U'), cells 100..119 = 0x20, cursor (0,5).
- Assert in_clear mid-scroll, plus in_char_valid with 0x42 in the same IDLE cycle as another in_clear -> scroll completes, then 120-cycle clear. 0x42 is never written; ready stays low throughout.
- Read addr 125 -> 0x20/16'hffff/16'h001f. Send 0x07 -> accepted, cursor and cells unchanged. Assert in_rst mid-clear -> clear restarts from cell 0.
